// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver frame-tail logic: tail FSM state
// encodings, parity type constants and sticky status bit positions.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STOP1 = 2'd1,
        ST_STOP2 = 2'd2
    } tail_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int ERR_PAR_IDX = 0;
    localparam int ERR_STP_IDX = 1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational expected-parity generator: the bit that makes DATA plus the
// parity bit even (PAR_EVEN) or odd (PAR_ODD).
module uart_parity_calc
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] DATA,
    input  logic              PAR_TYP,
    output logic              PAR_BIT
);

    // Odd parity inverts the plain XOR reduction of the data word
    assign PAR_BIT = (^DATA) ^ (PAR_TYP == PAR_ODD);

endmodule

// File: rtl/uart_frame_chk.sv
// Frame-tail checker for the UART receiver: evaluates the optional parity bit
// and one or two stop bits at the oversampling sample point, emits one-cycle
// error pulses and a frame-done strobe for the RX FSM.
// Optional feature macro: UART_FRAME_CHK_STICKY_EN enables the sticky ERR_STAT
// register and its ERR_CLR clear; without it ERR_STAT is tied to zero.
module uart_frame_chk
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6,
    parameter int DATA_W     = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SAMPLED_BIT,
    input  logic [PRESCALE_W-1:0] EDGE_CNT,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic [DATA_W-1:0]     DATA,
    input  logic                  PAR_CHK_EN,
    input  logic                  STP_CHK_EN,
    input  logic                  PAR_TYP,
    input  logic                  TWO_STOP,
    input  logic                  ERR_CLR,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  FRAME_DONE,
    output logic [1:0]            ERR_STAT
);

    tail_state_t state;
    logic        stb;
    logic        exp_par;
    logic        abandon;
    logic        par_eval;
    logic        stp_eval;
    logic        par_bad;
    logic        stp_bad;

    uart_parity_calc #(
        .DATA_W (DATA_W)
    ) u_parity_calc (
        .DATA    (DATA),
        .PAR_TYP (PAR_TYP),
        .PAR_BIT (exp_par)
    );

    // Sample point sits two oversampling edges before the end of the bit
    assign stb = (EDGE_CNT == (PRESCALE - PRESCALE_W'(2)));

    // Once past IDLE, losing both enables means the RX FSM gave up on the frame
    assign abandon  = (state != ST_IDLE) && !PAR_CHK_EN && !STP_CHK_EN;
    assign par_eval = (state == ST_IDLE) && stb && PAR_CHK_EN;
    assign stp_eval = stb && STP_CHK_EN && !PAR_CHK_EN;

    // Error verdicts for the current cycle, registered into the pulses below
    assign par_bad = par_eval && (SAMPLED_BIT != exp_par);
    assign stp_bad = abandon || (stp_eval && !SAMPLED_BIT);

    // Tail FSM with registered one-cycle error pulses and frame-done strobe
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            PAR_ERR    <= par_bad;
            STP_ERR    <= stp_bad;
            FRAME_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (par_eval) begin
                        state <= ST_STOP1;
                    end else if (stp_eval) begin
                        if (TWO_STOP) begin
                            state <= ST_STOP2;
                        end else begin
                            FRAME_DONE <= 1'b1;
                        end
                    end
                end
                ST_STOP1: begin
                    if (abandon) begin
                        FRAME_DONE <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (stp_eval) begin
                        if (TWO_STOP) begin
                            state <= ST_STOP2;
                        end else begin
                            FRAME_DONE <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end
                end
                ST_STOP2: begin
                    if (abandon || stp_eval) begin
                        FRAME_DONE <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_FRAME_CHK_STICKY_EN
    logic [1:0] err_stat;
    logic [1:0] stat_set;

    assign stat_set[ERR_PAR_IDX] = par_bad;
    assign stat_set[ERR_STP_IDX] = stp_bad;

    // Sticky status: clear first, then a simultaneous new error sets again
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_stat <= 2'b00;
        end else begin
            err_stat <= (ERR_CLR ? 2'b00 : err_stat) | stat_set;
        end
    end

    assign ERR_STAT = err_stat;
`else
    assign ERR_STAT = 2'b00;
`endif

endmodule

// File: tb/tb_uart_frame_chk.sv
// Self-checking bench for uart_frame_chk: directed scenarios from the frame
// rules plus randomized frames compared against a frame-level reference model.
module tb_uart_frame_chk;

    logic       CLK;
    logic       RST;
    logic       SAMPLED_BIT;
    logic [5:0] EDGE_CNT;
    logic [5:0] PRESCALE;
    logic [7:0] DATA;
    logic       PAR_CHK_EN;
    logic       STP_CHK_EN;
    logic       PAR_TYP;
    logic       TWO_STOP;
    logic       ERR_CLR;
    logic       PAR_ERR;
    logic       STP_ERR;
    logic       FRAME_DONE;
    logic [1:0] ERR_STAT;

    typedef struct packed {
        logic       par_err;
        logic       stp1_err;
        logic       done1;
        logic       stp2_err;
        logic       done2;
        logic [1:0] stat;
        logic [7:0] spurious;
    } obs_t;

    int         vectors;
    int         miscompares;
    int         spurious;
    logic [1:0] exp_stat;

    uart_frame_chk #(
        .PRESCALE_W (6),
        .DATA_W     (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SAMPLED_BIT (SAMPLED_BIT),
        .EDGE_CNT    (EDGE_CNT),
        .PRESCALE    (PRESCALE),
        .DATA        (DATA),
        .PAR_CHK_EN  (PAR_CHK_EN),
        .STP_CHK_EN  (STP_CHK_EN),
        .PAR_TYP     (PAR_TYP),
        .TWO_STOP    (TWO_STOP),
        .ERR_CLR     (ERR_CLR),
        .PAR_ERR     (PAR_ERR),
        .STP_ERR     (STP_ERR),
        .FRAME_DONE  (FRAME_DONE),
        .ERR_STAT    (ERR_STAT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // What ERR_STAT should read given the modelled sticky value
    function automatic logic [1:0] sticky_view(input logic [1:0] s);
`ifdef UART_FRAME_CHK_STICKY_EN
        return s;
`else
        return 2'b00 & s;
`endif
    endfunction

    // Frame-level reference: parity by counting ones, stop error = bit low
    function automatic obs_t model_frame(input logic [7:0] d, input logic has_par,
                                         input logic typ, input logic pbit,
                                         input logic two, input logic s1,
                                         input logic s2, input logic clr);
        obs_t       m;
        int         ones;
        logic [1:0] st;
        m    = '0;
        ones = $countones(d) + int'(pbit);
        m.par_err  = has_par && ((ones % 2) != int'(typ));
        m.stp1_err = !s1;
        m.done1    = !two;
        m.stp2_err = two && !s2;
        m.done2    = two;
        st = exp_stat | {two && !s1, m.par_err};
        if (clr) st = 2'b00;
        st[1] = st[1] | (two ? !s2 : !s1);
        exp_stat = st;
        m.stat = sticky_view(st);
        return m;
    endfunction

    // Drive one bit period; return the pulses seen right after its sample point
    task automatic drive_bit(input logic pen, input logic sen, input logic bitv,
                             input logic clr, output logic g_par,
                             output logic g_stp, output logic g_done);
        g_par = 1'b0; g_stp = 1'b0; g_done = 1'b0;
        for (int e = 0; e < int'(PRESCALE); e++) begin
            PAR_CHK_EN  = pen;
            STP_CHK_EN  = sen;
            SAMPLED_BIT = bitv;
            EDGE_CNT    = 6'(e);
            ERR_CLR     = clr && (e == int'(PRESCALE) - 2);
            @(posedge CLK); #1;
            if (e == int'(PRESCALE) - 2) begin
                g_par = PAR_ERR; g_stp = STP_ERR; g_done = FRAME_DONE;
            end else if (PAR_ERR || STP_ERR || FRAME_DONE) begin
                spurious++;
            end
        end
        ERR_CLR    = 1'b0;
        PAR_CHK_EN = 1'b0;
        STP_CHK_EN = 1'b0;
    endtask

    // Drive a whole frame tail preceded and followed by idle bit periods
    task automatic run_frame(input logic [7:0] d, input logic has_par,
                             input logic typ, input logic pbit, input logic two,
                             input logic s1, input logic s2, input logic clr,
                             output obs_t o);
        logic a, b, c;
        o = '0;
        spurious = 0;
        DATA = d; PAR_TYP = typ; TWO_STOP = two;
        for (int i = 0; i < 2; i++) begin
            drive_bit(1'b0, 1'b0, 1'($urandom), 1'b0, a, b, c);
            if (a || b || c) spurious++;
        end
        if (has_par) begin
            drive_bit(1'b1, 1'b0, pbit, 1'b0, o.par_err, b, c);
            if (b || c) spurious++;
        end
        drive_bit(1'b0, 1'b1, s1, clr && !two, a, o.stp1_err, o.done1);
        if (a) spurious++;
        if (two) begin
            drive_bit(1'b0, 1'b1, s2, clr, a, o.stp2_err, o.done2);
            if (a) spurious++;
        end
        drive_bit(1'b0, 1'b0, 1'b1, 1'b0, a, b, c);
        if (a || b || c) spurious++;
        o.stat     = ERR_STAT;
        o.spurious = 8'(spurious);
    endtask

    task automatic test_reset();
        RST = 1'b0; SAMPLED_BIT = 1'b1; EDGE_CNT = '0; PRESCALE = 6'd8;
        DATA = '0; PAR_CHK_EN = 1'b0; STP_CHK_EN = 1'b0; PAR_TYP = 1'b0;
        TWO_STOP = 1'b0; ERR_CLR = 1'b0; exp_stat = 2'b00;
        repeat (3) @(posedge CLK);
        #1;
        vectors++;
        if ({PAR_ERR, STP_ERR, FRAME_DONE, ERR_STAT} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: got %b want 00000", {PAR_ERR, STP_ERR, FRAME_DONE, ERR_STAT});
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        vectors++;
        if ({PAR_ERR, STP_ERR, FRAME_DONE, ERR_STAT} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got %b want 00000", {PAR_ERR, STP_ERR, FRAME_DONE, ERR_STAT});
        end
    endtask

    task automatic test_frame(input string name, input logic [5:0] pre,
                              input logic [7:0] d, input logic has_par,
                              input logic typ, input logic pbit, input logic two,
                              input logic s1, input logic s2, input logic clr);
        obs_t o, m;
        PRESCALE = pre;
        run_frame(d, has_par, typ, pbit, two, s1, s2, clr, o);
        m = model_frame(d, has_par, typ, pbit, two, s1, s2, clr);
        vectors++;
        if (o !== m) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h want %h", name, o, m);
        end
    endtask

    task automatic test_priority();
        logic a, b, c;
        PRESCALE = 6'd8; DATA = 8'h0F; PAR_TYP = 1'b0; TWO_STOP = 1'b0;
        drive_bit(1'b1, 1'b1, 1'b1, 1'b0, a, b, c);
        vectors++;
        if ({a, b, c} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL priority_par: got %b want 100", {a, b, c});
        end
        exp_stat[0] = 1'b1;
        drive_bit(1'b0, 1'b1, 1'b1, 1'b0, a, b, c);
        vectors++;
        if ({a, b, c, ERR_STAT} !== {3'b001, sticky_view(exp_stat)}) begin
            miscompares++;
            $display("[TB] FAIL priority_stop: got %b want %b", {a, b, c, ERR_STAT}, {3'b001, sticky_view(exp_stat)});
        end
    endtask

    task automatic test_abandon();
        logic a, b, c;
        PRESCALE = 6'd8; DATA = 8'h3C; TWO_STOP = 1'b1;
        drive_bit(1'b0, 1'b1, 1'b1, 1'b0, a, b, c);
        vectors++;
        if ({a, b, c} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL abandon_first_stop: got %b want 000", {a, b, c});
        end
        EDGE_CNT = '0;
        @(posedge CLK); #1;
        exp_stat[1] = 1'b1;
        vectors++;
        if ({PAR_ERR, STP_ERR, FRAME_DONE, ERR_STAT} !== {3'b011, sticky_view(exp_stat)}) begin
            miscompares++;
            $display("[TB] FAIL abandon_pulse: got %b want %b", {PAR_ERR, STP_ERR, FRAME_DONE, ERR_STAT}, {3'b011, sticky_view(exp_stat)});
        end
        @(posedge CLK); #1;
        vectors++;
        if ({PAR_ERR, STP_ERR, FRAME_DONE} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL abandon_one_cycle: got %b want 000", {PAR_ERR, STP_ERR, FRAME_DONE});
        end
        test_frame("abandon_next_frame", 6'd8, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_clear();
        test_frame("clear_set", 6'd8, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        test_frame("clear_vs_set", 6'd8, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        ERR_CLR = 1'b1; EDGE_CNT = '0;
        @(posedge CLK); #1;
        ERR_CLR = 1'b0;
        exp_stat = 2'b00;
        vectors++;
        if (ERR_STAT !== sticky_view(exp_stat)) begin
            miscompares++;
            $display("[TB] FAIL clear_alone: got %b want %b", ERR_STAT, sticky_view(exp_stat));
        end
    endtask

    task automatic test_reset_mid();
        PRESCALE = 6'd8; DATA = 8'h03; PAR_TYP = 1'b0; TWO_STOP = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            PAR_CHK_EN = 1'b1; SAMPLED_BIT = 1'b1; EDGE_CNT = 6'(e);
            @(posedge CLK); #1;
        end
        PAR_CHK_EN = 1'b0;
        vectors++;
        if (PAR_ERR !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_par: got %b want 1", PAR_ERR);
        end
        RST = 1'b0;
        #1;
        exp_stat = 2'b00;
        vectors++;
        if ({PAR_ERR, STP_ERR, FRAME_DONE, ERR_STAT} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_async: got %b want 00000", {PAR_ERR, STP_ERR, FRAME_DONE, ERR_STAT});
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        test_frame("reset_mid_next", 6'd8, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_no_stb();
        int hits;
        hits = 0;
        PRESCALE = 6'd8; DATA = 8'hFF; TWO_STOP = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int e = 0; e < 8; e++) begin
                if (e != 6) begin
                    PAR_CHK_EN = r[0]; STP_CHK_EN = 1'b1; SAMPLED_BIT = 1'b0;
                    EDGE_CNT = 6'(e);
                    @(posedge CLK); #1;
                    if (PAR_ERR || STP_ERR || FRAME_DONE) hits++;
                end
            end
        end
        PAR_CHK_EN = 1'b0; STP_CHK_EN = 1'b0;
        @(posedge CLK); #1;
        vectors++;
        if (hits !== 0) begin
            miscompares++;
            $display("[TB] FAIL no_stb: got %0d pulses want 0", hits);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            test_frame("random_frame", 6'($urandom_range(4, 16)), 8'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_frame("basic_even", 6'd8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        test_frame("parity_odd_err", 6'd8, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        test_frame("two_stop_err", 6'd8, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        test_frame("min_prescale", 6'd4, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        test_priority();
        test_abandon();
        test_clear();
        test_reset_mid();
        test_no_stb();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_frame_chk.md
# uart_frame_chk

Parametrised frame-tail checker for the UART receiver, generalising the single-stop-bit checker. It checks the optional parity bit and one or two stop bits at the oversampling sample point, and reports per-frame error pulses and a frame-done strobe to the RX FSM. It also keeps optional sticky error status for the register interface. It sits between the data sampler/edge counter and the RX control FSM.

## Interface
- PRESCALE_W, 6: width of PRESCALE and EDGE_CNT.
- DATA_W, 8: received data width used for parity.
- CLK  in  1  receiver clock.
- RST  in  1  reset, asynchronous, active-low.
- SAMPLED_BIT  in  1  majority-voted bit from the data sampler.
- EDGE_CNT  in  PRESCALE_W  oversampling edge counter within the current bit.
- PRESCALE  in  PRESCALE_W  oversampling ratio; legal values are 4 and above.
- DATA  in  DATA_W  deserialised data word, stable during the parity and stop bits.
- PAR_CHK_EN  in  1  RX FSM is in the parity bit.
- STP_CHK_EN  in  1  RX FSM is in a stop bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- TWO_STOP  in  1  0 = one stop bit, 1 = two stop bits.
- ERR_CLR  in  1  clears the sticky status.
- PAR_ERR  out  1  one-cycle parity error pulse.
- STP_ERR  out  1  one-cycle stop/framing error pulse.
- FRAME_DONE  out  1  one-cycle pulse after the last stop bit has been evaluated.
- ERR_STAT  out  2  sticky status, {stop, parity}.

## Operation
- Sample strobe STB = (EDGE_CNT == PRESCALE − 2), compared at PRESCALE_W bits. No sampling occurs outside STB.
- FSM states: IDLE, STOP1, STOP2.
  - IDLE + STB + PAR_CHK_EN:
    - PAR_ERR = (^DATA ^ SAMPLED_BIT) != PAR_TYP.
    - Go to STOP1.
  - IDLE + STB + STP_CHK_EN: evaluate the first stop bit.
    - If TWO_STOP = 1, go to STOP2.
    - Otherwise pulse FRAME_DONE and stay in IDLE.
  - STOP1 + STB + STP_CHK_EN: evaluate the first stop bit, then take the same TWO_STOP branch as above.
  - STOP2 + STB + STP_CHK_EN: evaluate the second stop bit, pulse FRAME_DONE, go to IDLE.
  - STOP1/STOP2 while both enables are low (FSM abandoned the frame): pulse STP_ERR and FRAME_DONE, go to IDLE.
  - If PAR_CHK_EN and STP_CHK_EN are both high, PAR_CHK_EN has priority.
- Stop bit evaluation: STP_ERR = ~SAMPLED_BIT.
- TWO_STOP and PAR_TYP are sampled at each STB. Changing them mid-frame takes effect at the next STB.
- Sticky status:
  - ERR_STAT bits set on the corresponding error pulse.
  - ERR_CLR clears them.
  - A set in the same cycle as ERR_CLR wins.

## Timing
- Reset values: all outputs 0, FSM in IDLE.
- Latency: PAR_ERR, STP_ERR and FRAME_DONE are registered and appear the cycle after the STB cycle.
- Error pulses last exactly one cycle. FRAME_DONE coincides with the final STP_ERR.
- ERR_STAT updates one cycle after the pulse-generating STB, i.e. in the same cycle as the pulse.
- Reset mid-frame: immediate return to IDLE, pulses cleared, no FRAME_DONE.
- An enable that is high while EDGE_CNT never reaches PRESCALE − 2 produces no output.

## Configuration
- UART_FRAME_CHK_STICKY_EN:
  - Defined: ERR_STAT register and ERR_CLR logic are present.
  - Undefined: ERR_STAT is tied to 0 and ERR_CLR is ignored. Pulses and FRAME_DONE are unchanged.

## Structure
- Shared package/header uart_rx_pkg holds:
  - FSM state encodings (IDLE = 0, STOP1 = 1, STOP2 = 2).
  - PAR_EVEN / PAR_ODD constants.
  - ERR_STAT bit indices.
- One sub-module, uart_parity_calc: parameter DATA_W; inputs DATA and PAR_TYP; output expected parity bit; combinational.

## Test plan
- PRESCALE = 8, even parity, DATA = 8'hA5, parity bit 0, one stop bit = 1 -> PAR_ERR = 0, STP_ERR = 0; FRAME_DONE pulses the cycle after the stop-bit STB (EDGE_CNT = 6).
- Odd parity, DATA = 8'h01, parity bit 1 -> PAR_ERR pulses for one cycle; ERR_STAT = 2'b01.
- TWO_STOP = 1, second stop bit sampled 0 -> no FRAME_DONE after the first stop; STP_ERR and FRAME_DONE pulse together after the second; ERR_STAT[1] = 1.
- In STOP2, drop STP_CHK_EN before STB -> STP_ERR and FRAME_DONE pulse next cycle; FSM returns to IDLE.
- ERR_CLR asserted in the same cycle a new STP_ERR sets -> ERR_STAT[1] stays 1. ERR_CLR alone -> ERR_STAT = 0. With the macro undefined, ERR_STAT stays 0 throughout.
- RST asserted in STOP1 -> all outputs 0 immediately; the next frame is checked normally from IDLE.
